// File: rtl/fixed_decoder_if.sv
// ---------------------------------------------------------------------------
// fixed_decoder_if : handshake/data bundle between the residual source and
//                    the fixed-predictor decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fixed_decoder_if;
  logic               iEnable;
  logic               iStart;
  logic [2:0]         iOrder;
  logic [15:0]        iBlockSize;
  logic signed [15:0] iData;
  logic               iValid;
  logic signed [15:0] oSample;
  logic               oValid;
  logic               oDone;
  logic               oBusy;
  logic               oError;
  logic               oOverflow;

  modport master (
    output iEnable, iStart, iOrder, iBlockSize, iData, iValid,
    input  oSample, oValid, oDone, oBusy, oError, oOverflow
  );

  modport slave (
    input  iEnable, iStart, iOrder, iBlockSize, iData, iValid,
    output oSample, oValid, oDone, oBusy, oError, oOverflow
  );
endinterface

`default_nettype wire

// File: rtl/fixed_decoder.sv
// ---------------------------------------------------------------------------
// fixed_decoder : fixed (order 0..4) polynomial predictor reconstruction,
//                 warmup pass-through, one sample per cycle, latency 1.
// Option macro  : FIXED_DECODER_SAT_EN (saturate + sticky overflow flag)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fixed_decoder (
  input  wire logic       iClock,
  input  wire logic       iReset_n,
  fixed_decoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_PREDICT = 2'd2;

  logic [1:0]         r_state;
  logic [15:0]        r_count;
  logic [2:0]         r_warm;
  logic [2:0]         r_order;
  logic signed [15:0] r_x1, r_x2, r_x3, r_x4;
  logic signed [15:0] r_sample;
  logic               r_valid, r_done, r_busy, r_error;

  logic               w_start_bad;
  logic               w_accept;
  logic signed [19:0] w_r, w_x1, w_x2, w_x3, w_x4;
  logic signed [19:0] w_pred;
  logic signed [15:0] w_rule;
  logic signed [15:0] w_sample;

  assign w_start_bad = (bus.iOrder > 3'd4) || (bus.iBlockSize == 16'd0);
  assign w_accept    = bus.iValid && (r_state != S_IDLE);

  assign w_r  = {{4{bus.iData[15]}}, bus.iData};
  assign w_x1 = {{4{r_x1[15]}}, r_x1};
  assign w_x2 = {{4{r_x2[15]}}, r_x2};
  assign w_x3 = {{4{r_x3[15]}}, r_x3};
  assign w_x4 = {{4{r_x4[15]}}, r_x4};

  // 20 bits covers the worst order-4 magnitude (16 * 32768 - small slack)
  always_comb begin
    w_pred = w_r;
    case (r_order)
      3'd1:    w_pred = w_r + w_x1;
      3'd2:    w_pred = w_r + (w_x1 <<< 1) - w_x2;
      3'd3:    w_pred = w_r + (w_x1 <<< 1) + w_x1 - (w_x2 <<< 1) - w_x2 + w_x3;
      3'd4:    w_pred = w_r + (w_x1 <<< 2) - (w_x2 <<< 2) - (w_x2 <<< 1)
                        + (w_x3 <<< 2) - w_x4;
      default: w_pred = w_r;
    endcase
  end

`ifdef FIXED_DECODER_SAT_EN
  logic w_ovf;
  logic r_overflow;

  assign w_ovf  = !((&w_pred[19:15]) || !(|w_pred[19:15]));
  assign w_rule = w_ovf ? (w_pred[19] ? 16'sh8000 : 16'sh7FFF) : w_pred[15:0];

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_overflow <= 1'b0;
    end else if (bus.iEnable) begin
      if (bus.iStart) begin
        if (!w_start_bad) r_overflow <= 1'b0;
      end else if (w_accept && (r_state == S_PREDICT) && w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.oOverflow = r_overflow;
`else
  logic w_unused_hi;

  // Wrap mode: the upper bits of the wide sum are intentionally discarded
  assign w_unused_hi   = ^w_pred[19:16];
  assign w_rule        = w_pred[15:0];
  assign bus.oOverflow = 1'b0;
`endif

  assign w_sample = (r_state == S_WARMUP) ? bus.iData : w_rule;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state  <= S_IDLE;
      r_count  <= 16'd0;
      r_warm   <= 3'd0;
      r_order  <= 3'd0;
      r_x1     <= 16'sd0;
      r_x2     <= 16'sd0;
      r_x3     <= 16'sd0;
      r_x4     <= 16'sd0;
      r_sample <= 16'sd0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else if (bus.iEnable) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (bus.iStart) begin
        if (w_start_bad) begin
          r_error <= 1'b1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_count <= 16'd0;
          r_warm  <= 3'd0;
        end else begin
          r_order <= bus.iOrder;
          r_count <= bus.iBlockSize;
          r_warm  <= 3'd0;
          r_x1    <= 16'sd0;
          r_x2    <= 16'sd0;
          r_x3    <= 16'sd0;
          r_x4    <= 16'sd0;
          r_busy  <= 1'b1;
          r_state <= (bus.iOrder != 3'd0) ? S_WARMUP : S_PREDICT;
        end
      end else if (w_accept) begin
        r_sample <= w_sample;
        r_valid  <= 1'b1;
        r_x1     <= w_sample;
        r_x2     <= r_x1;
        r_x3     <= r_x2;
        r_x4     <= r_x3;
        r_count  <= r_count - 16'd1;
        if (r_count == 16'd1) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_warm  <= 3'd0;
          r_state <= S_IDLE;
        end else if (r_state == S_WARMUP) begin
          r_warm <= r_warm + 3'd1;
          if (r_warm + 3'd1 == r_order) r_state <= S_PREDICT;
        end
      end
    end else begin
      // Pulses stay one cycle wide even while the pipeline is frozen
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end
  end

  assign bus.oSample = r_sample;
  assign bus.oValid  = r_valid;
  assign bus.oDone   = r_done;
  assign bus.oBusy   = r_busy;
  assign bus.oError  = r_error;

endmodule

`default_nettype wire

// File: tb/tb_fixed_decoder.sv
// Testbench for fixed_decoder: directed cases plus random subframes checked
// against a binomial-coefficient reference model.
`default_nettype none

module tb_fixed_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fixed_decoder_if bus();

  fixed_decoder dut (
    .iClock   (clk),
    .iReset_n (rst_n),
    .bus      (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int m_hist[$];
  int m_remain = 0;
  int m_order  = 0;
  int m_idx    = 0;
  bit m_ovf    = 0;

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int binom(int n, int k);
    int b = 1;
    for (int i = 1; i <= k; i++) b = b * (n - k + i) / i;
    return b;
  endfunction

  // s = r + sum_k (-1)^(k+1) * C(order,k) * x_k
  function automatic int predict(int order, int r);
    int s = r;
    for (int k = 1; k <= order; k++)
      s += ((k % 2) ? 1 : -1) * binom(order, k) * m_hist[k-1];
    return s;
  endfunction

  function automatic int out_rule(int v, output bit ovf);
    int w;
`ifdef FIXED_DECODER_SAT_EN
    ovf = (v > 32767) || (v < -32768);
    if (v > 32767)       w = 32767;
    else if (v < -32768) w = -32768;
    else                 w = v;
`else
    ovf = 1'b0;
    w = v & 32'h0000FFFF;
    if (w > 32767) w -= 65536;
`endif
    return w;
  endfunction

  task automatic start_sub(int order, int bs);
    bus.iEnable    = 1'b1;
    bus.iStart     = 1'b1;
    bus.iOrder     = 3'(order);
    bus.iBlockSize = 16'(bs);
    bus.iValid     = 1'b1;
    bus.iData      = 16'($urandom);
    tick();
    chk("start_busy",  bus.oBusy, 1);
    chk("start_valid", bus.oValid, 0);
    chk("start_done",  bus.oDone, 0);
    chk("start_err",   bus.oError, 0);
    chk("start_ovf",   bus.oOverflow, 0);
    m_hist   = '{0, 0, 0, 0};
    m_remain = bs;
    m_order  = order;
    m_idx    = 0;
    m_ovf    = 1'b0;
    bus.iStart = 1'b0;
    bus.iValid = 1'b0;
  endtask

  task automatic feed(int d);
    int s;
    bit o;
    bus.iValid = 1'b1;
    bus.iData  = 16'(d);
    tick();
    o = 1'b0;
    if (m_idx < m_order) s = out_rule(d, o);
    else                 s = out_rule(predict(m_order, d), o);
    m_ovf = m_ovf | o;
    chk("sample", bus.oSample, s);
    chk("valid",  bus.oValid, 1);
    chk("done",   bus.oDone, (m_remain == 1));
    chk("busy",   bus.oBusy, (m_remain != 1));
    chk("ovf",    bus.oOverflow, m_ovf);
    m_hist.push_front(s);
    m_remain--;
    m_idx++;
    bus.iValid = 1'b0;
  endtask

  task automatic stall();
    bus.iEnable    = 1'b0;
    bus.iStart     = 1'b1;
    bus.iOrder     = 3'd0;
    bus.iBlockSize = 16'd1;
    bus.iValid     = 1'b1;
    bus.iData      = 16'($urandom);
    tick();
    chk("stall_valid", bus.oValid, 0);
    chk("stall_busy",  bus.oBusy, (m_remain > 0));
    chk("stall_err",   bus.oError, 0);
    bus.iEnable = 1'b1;
    bus.iStart  = 1'b0;
    bus.iValid  = 1'b0;
  endtask

  task automatic idle_tick();
    tick();
    chk("idle_valid", bus.oValid, 0);
    chk("idle_done",  bus.oDone, 0);
  endtask

  task automatic bad_start(int order, int bs);
    bus.iStart     = 1'b1;
    bus.iOrder     = 3'(order);
    bus.iBlockSize = 16'(bs);
    tick();
    chk("bad_err",  bus.oError, 1);
    chk("bad_busy", bus.oBusy, 0);
    bus.iStart = 1'b0;
    m_remain = 0;
    for (int i = 0; i < 3; i++) begin
      bus.iValid = 1'b1;
      bus.iData  = 16'sd77;
      tick();
      chk("bad_novalid", bus.oValid, 0);
      chk("bad_err_pulse", bus.oError, 0);
      chk("bad_busy_after", bus.oBusy, 0);
    end
    bus.iValid = 1'b0;
  endtask

  initial begin
    int q[$];
    int order, bs, nfeed, d;

    bus.iEnable = 1'b1; bus.iStart = 1'b0; bus.iOrder = 3'd0;
    bus.iBlockSize = 16'd0; bus.iData = 16'sd0; bus.iValid = 1'b0;
    #2;
    chk("rst_sample", bus.oSample, 0);
    chk("rst_valid",  bus.oValid, 0);
    chk("rst_busy",   bus.oBusy, 0);
    chk("rst_err",    bus.oError, 0);
    chk("rst_ovf",    bus.oOverflow, 0);
    #10 rst_n = 1'b1;
    idle_tick();

    // Order 0 pass-through
    start_sub(0, 3);
    q = '{5, -2, 7};
    foreach (q[i]) feed(q[i]);
    chk("o0_last", bus.oSample, 7);
    idle_tick();

    // Order 2
    start_sub(2, 5);
    q = '{10, 12, 1, 0, -1};
    foreach (q[i]) feed(q[i]);
    chk("o2_last", bus.oSample, 20);
    idle_tick();

    // Order 4
    start_sub(4, 6);
    q = '{1, 2, 3, 4, 0, 0};
    foreach (q[i]) feed(q[i]);
    chk("o4_last", bus.oSample, 6);
    idle_tick();

    // Output-rule boundary
    start_sub(1, 2);
    feed(32767);
    feed(1);
`ifdef FIXED_DECODER_SAT_EN
    chk("edge_sample", bus.oSample, 32767);
    chk("edge_ovf", bus.oOverflow, 1);
`else
    chk("edge_sample", bus.oSample, -32768);
    chk("edge_ovf", bus.oOverflow, 0);
`endif
    idle_tick();

    // Block shorter than order ends inside warmup
    start_sub(4, 2);
    feed(100);
    feed(-100);
    idle_tick();

    bad_start(5, 4);
    bad_start(1, 0);

    // Reset mid-subframe
    start_sub(3, 10);
    q = '{3, -8, 20, 4};
    foreach (q[i]) feed(q[i]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sample", bus.oSample, 0);
    chk("mid_rst_valid",  bus.oValid, 0);
    chk("mid_rst_done",   bus.oDone, 0);
    chk("mid_rst_busy",   bus.oBusy, 0);
    chk("mid_rst_err",    bus.oError, 0);
    chk("mid_rst_ovf",    bus.oOverflow, 0);
    #12 rst_n = 1'b1;
    m_remain = 0;
    bus.iValid = 1'b1;
    bus.iData  = 16'sd55;
    tick();
    chk("post_rst_novalid", bus.oValid, 0);
    bus.iValid = 1'b0;
    start_sub(0, 1);
    feed(-9);
    chk("post_rst_sample", bus.oSample, -9);
    idle_tick();

    // Random subframes, including enable stalls and restarts while busy
    for (int n = 0; n < 30; n++) begin
      order = int'($urandom_range(0, 4));
      bs    = int'($urandom_range(1, 8));
      nfeed = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, bs - 1)) : bs;
      start_sub(order, bs);
      for (int i = 0; i < nfeed; i++) begin
        if ($urandom_range(0, 4) == 0) stall();
        if (i < order) d = int'($urandom_range(0, 65535)) - 32768;
        else           d = int'($urandom_range(0, 400)) - 200;
        feed(d);
      end
      if (nfeed == bs || $urandom_range(0, 1) == 0) idle_tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
